// File: rtl/multicycle_control_fsm.sv
// Control sequencer for the multi-cycle mini CPU: steps FETCH/DECODE/EXEC/MEM/WB and drives the 14-bit ControlLine word.
// Optional build macro CYCLE_COUNT_EN adds the INSTR_COUNT / CYCLE_COUNT performance counters and the CTR_W parameter.
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 255
`ifdef CYCLE_COUNT_EN
  ,
  parameter int unsigned CTR_W       = 32
`endif
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             RUN,
  input  logic [3:0]       OPCODE,
  input  logic             MEM_READY,
  output logic [13:0]      ControlLine,
  output logic [3:0]       STATE,
  output logic             INSTR_DONE,
  output logic             HALTED,
  output logic             ILLEGAL,
  output logic             MEM_TIMEOUT_ERR
`ifdef CYCLE_COUNT_EN
  ,
  output logic [CTR_W-1:0] INSTR_COUNT,
  output logic [CTR_W-1:0] CYCLE_COUNT
`endif
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_R     = 4'd7,
    S_WB_I     = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd15
  } state_e;

  localparam logic [3:0] OP_R    = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_LW   = 4'd2;
  localparam logic [3:0] OP_SW   = 4'd3;
  localparam logic [3:0] OP_BEQ  = 4'd4;
  localparam logic [3:0] OP_J    = 4'd5;
  localparam logic [3:0] OP_HALT = 4'd15;

  // Bits 13/12 of the FETCH word are the PCWRITE/IRWRITE strobes gated by RUN & MEM_READY.
  localparam logic [13:0] CW_FETCH    = 14'h3020;
  localparam logic [13:0] CW_DECODE   = 14'h0060;
  localparam logic [13:0] CW_EXEC_R   = 14'h0090;
  localparam logic [13:0] CW_EXEC_I   = 14'h00C0;
  localparam logic [13:0] CW_MEM_ADDR = 14'h00C0;
  localparam logic [13:0] CW_MEM_RD   = 14'h0000;
  localparam logic [13:0] CW_MEM_WR   = 14'h0002;
  localparam logic [13:0] CW_WB_R     = 14'h0900;
  localparam logic [13:0] CW_WB_I     = 14'h0100;
  localparam logic [13:0] CW_WB_MEM   = 14'h0300;
  localparam logic [13:0] CW_BRANCH   = 14'h008D;
  localparam logic [13:0] CW_JUMP     = 14'h2004;
  localparam logic [13:0] CW_NONE     = 14'h0000;

  // The wait counter only has to reach MEM_TIMEOUT-1; the cycle after that is the fault.
  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (MEM_TIMEOUT == 0) ? '0 : WAIT_W'(MEM_TIMEOUT - 1);
  localparam bit TMO_EN = (MEM_TIMEOUT != 0);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              illegal_q, illegal_d;
  logic              tmo_err_q, tmo_err_d;
  logic              is_load_q, is_load_d;
  logic              fetch_go;
  logic              mem_wait;
  logic              instr_done;
  logic [13:0]       ctrl_word;

  assign fetch_go = RUN & MEM_READY;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      tmo_err_q <= 1'b0;
      is_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      tmo_err_q <= tmo_err_d;
      is_load_q <= is_load_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    tmo_err_d  = tmo_err_q;
    is_load_d  = is_load_q;
    wait_d     = '0;
    mem_wait   = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_wait = RUN & ~MEM_READY;
        if (fetch_go) state_d = S_DECODE;
      end
      S_DECODE: begin
        is_load_d = (OPCODE == OP_LW);
        case (OPCODE)
          OP_R:    state_d = S_EXEC_R;
          OP_ADDI: state_d = S_EXEC_I;
          OP_LW:   state_d = S_MEM_ADDR;
          OP_SW:   state_d = S_MEM_ADDR;
          OP_BEQ:  state_d = S_BRANCH;
          OP_J:    state_d = S_JUMP;
          OP_HALT: state_d = S_HALT;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = is_load_q ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (MEM_READY) state_d = S_WB_MEM;
        else           mem_wait = 1'b1;
      end
      S_MEM_WR: begin
        if (MEM_READY) begin
          state_d    = S_FETCH;
          instr_done = 1'b1;
        end else begin
          mem_wait = 1'b1;
        end
      end
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: begin
        state_d    = S_FETCH;
        instr_done = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // A wait run that reaches the limit overrides whatever the state case chose.
    if (mem_wait && TMO_EN) begin
      if (wait_q == WAIT_LAST) begin
        tmo_err_d = 1'b1;
        state_d   = S_HALT;
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end
  end

  always_comb begin
    ctrl_word = CW_NONE;
    case (state_q)
      S_FETCH:    ctrl_word = {fetch_go, fetch_go, CW_FETCH[11:0]};
      S_DECODE:   ctrl_word = CW_DECODE;
      S_EXEC_R:   ctrl_word = CW_EXEC_R;
      S_EXEC_I:   ctrl_word = CW_EXEC_I;
      S_MEM_ADDR: ctrl_word = CW_MEM_ADDR;
      S_MEM_RD:   ctrl_word = CW_MEM_RD;
      S_MEM_WR:   ctrl_word = CW_MEM_WR;
      S_WB_R:     ctrl_word = CW_WB_R;
      S_WB_I:     ctrl_word = CW_WB_I;
      S_WB_MEM:   ctrl_word = CW_WB_MEM;
      S_BRANCH:   ctrl_word = CW_BRANCH;
      S_JUMP:     ctrl_word = CW_JUMP;
      default:    ctrl_word = CW_NONE;
    endcase
  end

  // Reset must kill strobes such as MEMWRITE combinationally, not at the next edge.
  assign ControlLine     = RESET_N ? ctrl_word : CW_NONE;
  assign STATE           = state_q;
  assign INSTR_DONE      = instr_done;
  assign HALTED          = (state_q == S_HALT);
  assign ILLEGAL         = illegal_q;
  assign MEM_TIMEOUT_ERR = tmo_err_q;

`ifdef CYCLE_COUNT_EN
  logic [CTR_W-1:0] instr_cnt_q, cycle_cnt_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      instr_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      if (instr_done)        instr_cnt_q <= instr_cnt_q + CTR_W'(1);
      if (state_q != S_HALT) cycle_cnt_q <= cycle_cnt_q + CTR_W'(1);
    end
  end

  assign INSTR_COUNT = instr_cnt_q;
  assign CYCLE_COUNT = cycle_cnt_q;
`endif

  a_halt_absorbing: assert property (@(posedge CLK) disable iff (!RESET_N)
    (state_q == S_HALT) |=> (state_q == S_HALT));
  a_done_to_fetch: assert property (@(posedge CLK) disable iff (!RESET_N)
    instr_done |=> (state_q == S_FETCH));
  a_illegal_sticky: assert property (@(posedge CLK) disable iff (!RESET_N)
    illegal_q |=> illegal_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-instruction expected cycle traces from the instruction rules, checked every cycle.
module tb_multicycle_control_fsm;
  localparam int TMO = 4;

  logic        CLK;
  logic        RESET_N;
  logic        RUN;
  logic [3:0]  OPCODE;
  logic        MEM_READY;
  logic [13:0] ControlLine;
  logic [3:0]  STATE;
  logic        INSTR_DONE;
  logic        HALTED;
  logic        ILLEGAL;
  logic        MEM_TIMEOUT_ERR;
`ifdef CYCLE_COUNT_EN
  logic [31:0] INSTR_COUNT;
  logic [31:0] CYCLE_COUNT;
`endif

  int checks = 0;
  int passed = 0;

  // stim_q: {RUN, MEM_READY, OPCODE}; exp_q: {STATE, ControlLine, INSTR_DONE, ILLEGAL, MEM_TIMEOUT_ERR}
  logic [5:0]  stim_q[$];
  logic [20:0] exp_q[$];
  logic        m_ill;
  logic        m_tmo;
  logic [31:0] m_icnt;
  logic [31:0] m_ccnt;

  multicycle_control_fsm #(.MEM_TIMEOUT(TMO)) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .RUN(RUN),
    .OPCODE(OPCODE),
    .MEM_READY(MEM_READY),
    .ControlLine(ControlLine),
    .STATE(STATE),
    .INSTR_DONE(INSTR_DONE),
    .HALTED(HALTED),
    .ILLEGAL(ILLEGAL),
    .MEM_TIMEOUT_ERR(MEM_TIMEOUT_ERR)
`ifdef CYCLE_COUNT_EN
    ,
    .INSTR_COUNT(INSTR_COUNT),
    .CYCLE_COUNT(CYCLE_COUNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rop();
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic push(input logic run, input logic rdy, input logic [3:0] op,
                      input logic [3:0] st, input logic [13:0] ctrl, input logic done);
    stim_q.push_back({run, rdy, op});
    exp_q.push_back({st, ctrl, done, m_ill, m_tmo});
  endtask

  // Idle cycles (RUN=0), fetch stalls (RUN=1, memory not ready), then the fetch itself.
  task automatic plan_fetch(input int idle, input int fwait, input bit idle_rdy_rand);
    for (int i = 0; i < idle; i++)
      push(1'b0, idle_rdy_rand ? rbit() : 1'b1, rop(), 4'd0, 14'h0020, 1'b0);
    for (int i = 0; i < fwait; i++)
      push(1'b1, 1'b0, rop(), 4'd0, 14'h0020, 1'b0);
    push(1'b1, 1'b1, rop(), 4'd0, 14'h3020, 1'b0);
  endtask

  task automatic plan_halt_cycles(input int n);
    for (int i = 0; i < n; i++)
      push(rbit(), rbit(), rop(), 4'd15, 14'h0000, 1'b0);
  endtask

  // DECODE onward for one opcode; mwait = memory-not-ready cycles in MEM_RD / MEM_WR.
  task automatic plan_body(input logic [3:0] op, input int mwait);
    push(rbit(), rbit(), op, 4'd1, 14'h0060, 1'b0);
    case (op)
      4'd0: begin
        push(rbit(), rbit(), op, 4'd2, 14'h0090, 1'b0);
        push(rbit(), rbit(), op, 4'd7, 14'h0900, 1'b1);
      end
      4'd1: begin
        push(rbit(), rbit(), op, 4'd3, 14'h00C0, 1'b0);
        push(rbit(), rbit(), op, 4'd8, 14'h0100, 1'b1);
      end
      4'd2: begin
        push(rbit(), rbit(), op, 4'd4, 14'h00C0, 1'b0);
        for (int i = 0; i < mwait; i++) push(rbit(), 1'b0, op, 4'd5, 14'h0000, 1'b0);
        push(rbit(), 1'b1, op, 4'd5, 14'h0000, 1'b0);
        push(rbit(), rbit(), op, 4'd9, 14'h0300, 1'b1);
      end
      4'd3: begin
        push(rbit(), rbit(), op, 4'd4, 14'h00C0, 1'b0);
        for (int i = 0; i < mwait; i++) push(rbit(), 1'b0, op, 4'd6, 14'h0002, 1'b0);
        push(rbit(), 1'b1, op, 4'd6, 14'h0002, 1'b1);
      end
      4'd4: push(rbit(), rbit(), op, 4'd10, 14'h008D, 1'b1);
      4'd5: push(rbit(), rbit(), op, 4'd11, 14'h2004, 1'b1);
      4'd15: plan_halt_cycles(5);
      default: m_ill = 1'b1;
    endcase
  endtask

  // Drives each planned cycle at the falling edge and compares every output against the plan.
  task automatic run_plan();
    logic [5:0]  s;
    logic [20:0] e;
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      RUN = s[5];
      MEM_READY = s[4];
      OPCODE = s[3:0];
      #1;
      checks++;
      if (STATE !== e[20:17])
        $display("FAIL state t=%0t: got %0d expected %0d", $time, STATE, e[20:17]);
      else passed++;
      checks++;
      if (ControlLine !== e[16:3])
        $display("FAIL control_line t=%0t state=%0d: got %h expected %h", $time, STATE, ControlLine, e[16:3]);
      else passed++;
      checks++;
      if (INSTR_DONE !== e[2])
        $display("FAIL instr_done t=%0t: got %b expected %b", $time, INSTR_DONE, e[2]);
      else passed++;
      checks++;
      if (ILLEGAL !== e[1])
        $display("FAIL illegal t=%0t: got %b expected %b", $time, ILLEGAL, e[1]);
      else passed++;
      checks++;
      if (MEM_TIMEOUT_ERR !== e[0])
        $display("FAIL mem_timeout_err t=%0t: got %b expected %b", $time, MEM_TIMEOUT_ERR, e[0]);
      else passed++;
      checks++;
      if (HALTED !== (e[20:17] == 4'd15))
        $display("FAIL halted t=%0t: got %b expected %b", $time, HALTED, (e[20:17] == 4'd15));
      else passed++;
`ifdef CYCLE_COUNT_EN
      checks++;
      if (INSTR_COUNT !== m_icnt)
        $display("FAIL instr_count t=%0t: got %0d expected %0d", $time, INSTR_COUNT, m_icnt);
      else passed++;
      checks++;
      if (CYCLE_COUNT !== m_ccnt)
        $display("FAIL cycle_count t=%0t: got %0d expected %0d", $time, CYCLE_COUNT, m_ccnt);
      else passed++;
`endif
      if (e[2]) m_icnt = m_icnt + 32'd1;
      if (e[20:17] != 4'd15) m_ccnt = m_ccnt + 32'd1;
      @(negedge CLK);
    end
  endtask

  // Asserts reset (with RUN & MEM_READY high so an ungated FETCH word would show) and releases it at a falling edge.
  task automatic test_reset();
    RESET_N = 1'b0;
    RUN = 1'b1;
    MEM_READY = 1'b1;
    OPCODE = rop();
    m_ill = 1'b0;
    m_tmo = 1'b0;
    m_icnt = '0;
    m_ccnt = '0;
    stim_q.delete();
    exp_q.delete();
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (STATE !== 4'd0) $display("FAIL reset_state: got %0d expected 0", STATE); else passed++;
      checks++;
      if (ControlLine !== 14'h0000) $display("FAIL reset_control_line: got %h expected 0000", ControlLine); else passed++;
      checks++;
      if ({INSTR_DONE, HALTED, ILLEGAL, MEM_TIMEOUT_ERR} !== 4'b0000)
        $display("FAIL reset_flags: got %b expected 0000", {INSTR_DONE, HALTED, ILLEGAL, MEM_TIMEOUT_ERR});
      else passed++;
`ifdef CYCLE_COUNT_EN
      checks++;
      if ({INSTR_COUNT, CYCLE_COUNT} !== 64'd0)
        $display("FAIL reset_counters: got %0d/%0d expected 0/0", INSTR_COUNT, CYCLE_COUNT);
      else passed++;
`endif
      @(negedge CLK);
      @(negedge CLK);
    end
    RESET_N = 1'b1;
  endtask

  task automatic test_r_type();
    plan_fetch(0, 0, 1'b0);
    plan_body(4'd0, 0);
    run_plan();
  endtask

  task automatic test_lw_wait();
    plan_fetch(0, 0, 1'b0);
    plan_body(4'd2, 3);
    run_plan();
  endtask

  task automatic test_run_gate();
    plan_fetch(3, 0, 1'b0);
    plan_body(4'd1, 0);
    run_plan();
  endtask

  task automatic test_illegal();
    plan_fetch(0, 0, 1'b0);
    plan_body(4'd7, 0);
    plan_fetch(0, 0, 1'b0);
    plan_body(4'd0, 0);
    run_plan();
    checks++;
    if (ILLEGAL !== 1'b1) $display("FAIL illegal_sticky: got %b expected 1", ILLEGAL); else passed++;
  endtask

  task automatic test_back_to_back();
    for (int op = 0; op < 6; op++) begin
      plan_fetch(0, 0, 1'b0);
      plan_body(4'(op), 0);
    end
    run_plan();
  endtask

  task automatic test_random();
    logic [3:0] op;
    int r;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      op = (r < 6) ? 4'(r) : 4'($urandom_range(6, 14));
      plan_fetch($urandom_range(0, 2), $urandom_range(0, TMO - 1), 1'b1);
      plan_body(op, $urandom_range(0, TMO - 1));
      run_plan();
    end
  endtask

  task automatic test_halt();
    plan_fetch(1, 0, 1'b1);
    plan_body(4'd15, 0);
    run_plan();
  endtask

  task automatic test_beq_j_halt();
    plan_fetch(0, 0, 1'b0);
    plan_body(4'd4, 0);
    plan_fetch(0, 0, 1'b0);
    plan_body(4'd5, 0);
    plan_fetch(0, 0, 1'b0);
    plan_body(4'd15, 0);
    run_plan();
  endtask

  // Memory never answers: TMO wait cycles in MEM_RD (op 2) or MEM_WR (op 3), then HALT with the error set.
  task automatic test_timeout_mem(input logic [3:0] op);
    plan_fetch(0, 0, 1'b0);
    push(rbit(), rbit(), op, 4'd1, 14'h0060, 1'b0);
    push(rbit(), rbit(), op, 4'd4, 14'h00C0, 1'b0);
    for (int i = 0; i < TMO; i++)
      push(rbit(), 1'b0, op, (op == 4'd2) ? 4'd5 : 4'd6, (op == 4'd2) ? 14'h0000 : 14'h0002, 1'b0);
    m_tmo = 1'b1;
    plan_halt_cycles(3);
    run_plan();
    checks++;
    if ({MEM_TIMEOUT_ERR, HALTED, STATE, ControlLine} !== {1'b1, 1'b1, 4'd15, 14'h0000})
      $display("FAIL timeout_final op=%0d: got err=%b halted=%b state=%0d ctrl=%h expected 1 1 15 0000",
               op, MEM_TIMEOUT_ERR, HALTED, STATE, ControlLine);
    else passed++;
  endtask

  task automatic test_timeout_fetch();
    for (int i = 0; i < TMO; i++) push(1'b1, 1'b0, rop(), 4'd0, 14'h0020, 1'b0);
    m_tmo = 1'b1;
    plan_halt_cycles(3);
    run_plan();
  endtask

  // Reset lands mid-cycle while MEM_WR holds MEMWRITE; the strobe must drop without waiting for a clock.
  task automatic test_reset_midwrite();
    plan_fetch(0, 0, 1'b0);
    push(rbit(), rbit(), 4'd3, 4'd1, 14'h0060, 1'b0);
    push(rbit(), rbit(), 4'd3, 4'd4, 14'h00C0, 1'b0);
    push(1'b1, 1'b0, 4'd3, 4'd6, 14'h0002, 1'b0);
    push(1'b1, 1'b0, 4'd3, 4'd6, 14'h0002, 1'b0);
    run_plan();
    MEM_READY = 1'b0;
    #2;
    checks++;
    if (ControlLine !== 14'h0002) $display("FAIL midwrite_hold: got %h expected 0002", ControlLine); else passed++;
    RESET_N = 1'b0;
    #1;
    checks++;
    if (ControlLine !== 14'h0000) $display("FAIL midwrite_reset_ctrl: got %h expected 0000", ControlLine); else passed++;
    checks++;
    if (STATE !== 4'd0) $display("FAIL midwrite_reset_state: got %0d expected 0", STATE); else passed++;
    test_reset();
  endtask

  initial begin
    RESET_N = 1'b0;
    RUN = 1'b0;
    MEM_READY = 1'b0;
    OPCODE = 4'd0;
    test_reset();
    test_r_type();
    test_lw_wait();
    test_run_gate();
    test_illegal();
    test_back_to_back();
    test_random();
    test_halt();
    test_reset();
    test_beq_j_halt();
    test_reset();
    test_timeout_mem(4'd3);
    test_reset();
    test_timeout_mem(4'd2);
    test_reset();
    test_timeout_fetch();
    test_reset();
    test_reset_midwrite();
    test_r_type();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
